// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive-FIFO read controller.
// FSM encoding, FIFO word layout and trigger-level decode.
package uart_rx_pkg;

    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = 5;
    localparam int DATA_W     = 11;
    localparam int TMO_W      = 16;

    // FIFO word layout: data byte on top, status flags below
    localparam int BYTE_HI  = 10;
    localparam int BYTE_LO  = 3;
    localparam int FLAG_BRK = 2;
    localparam int FLAG_FRM = 1;
    localparam int FLAG_PAR = 0;

    localparam logic [CNT_W-1:0] TRIG_L0 = 5'd1;
    localparam logic [CNT_W-1:0] TRIG_L1 = 5'd4;
    localparam logic [CNT_W-1:0] TRIG_L2 = 5'd8;
    localparam logic [CNT_W-1:0] TRIG_L3 = 5'd14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        ACK  = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] trig_level(input logic [1:0] sel);
        logic [CNT_W-1:0] lvl;
        unique case (sel)
            2'b00:   lvl = TRIG_L0;
            2'b01:   lvl = TRIG_L1;
            2'b10:   lvl = TRIG_L2;
            default: lvl = TRIG_L3;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/uart_rx_arb_tmo.sv
// Character-timeout timer for the receive FIFO.
// Counts idle cycles while data waits; flags when the limit is reached.
module uart_rx_tmo
    import uart_rx_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             count_nz,
    input  logic [TMO_W-1:0] cfg_timeout,
    output logic             tmo_flag
);

    logic [TMO_W-1:0] timer;
    logic             clr;

    assign clr = push | pop | ~count_nz;

    // Idle counter, saturating at the (possibly just lowered) limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (clr) begin
            timer <= '0;
        end else if (timer >= cfg_timeout) begin
            timer <= cfg_timeout;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Sticky timeout flag until FIFO activity or the FIFO drains
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_flag <= 1'b0;
        end else if (clr) begin
            tmo_flag <= 1'b0;
        end else if (cfg_timeout != '0 && timer == cfg_timeout) begin
            tmo_flag <= 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_arb.sv
// Round-robin read controller sharing one RX FIFO pop port between two cores.
// Optional macro UART_RX_ARB_DUAL_IRQ_EN splits irq into irq0/irq1 via cfg_owner.
module uart_rx_arb
    import uart_rx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  fifo_count,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_push,
    output logic              fifo_pop,
    input  logic [1:0]        req,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_empty,
    input  logic [1:0]        cfg_trig,
    input  logic [TMO_W-1:0]  cfg_timeout,
`ifdef UART_RX_ARB_DUAL_IRQ_EN
    input  logic              cfg_owner,
    output logic              irq0,
    output logic              irq1,
`else
    output logic              irq,
`endif
    output logic              tmo_flag
);

    state_t state;
    logic   gnt;
    logic   rr_last;
    logic   win;
    logic   count_nz;
    logic   trig_hit;
    logic   irq_cond;

    assign count_nz = |fifo_count;
    assign trig_hit = fifo_count >= trig_level(cfg_trig);
    assign irq_cond = trig_hit | tmo_flag;

    // Single requester wins outright; on contention the other core goes
    assign win = (&req) ? ~rr_last : req[1];

    // Arbitration / pop sequencing; the pop decision is taken on entry
    // to POP so the strobe is registered and can never hit an empty FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            rr_last  <= 1'b1;
            fifo_pop <= 1'b0;
            ack      <= 2'b00;
            rd_data  <= '0;
            rd_empty <= 1'b0;
        end else begin
            fifo_pop <= 1'b0;
            ack      <= 2'b00;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        gnt      <= win;
                        rr_last  <= win;
                        fifo_pop <= count_nz;
                        state    <= POP;
                    end
                end
                POP: begin
                    if (fifo_pop) begin
                        rd_data  <= fifo_data;
                        rd_empty <= 1'b0;
                    end else begin
                        rd_empty <= 1'b1;
                    end
                    ack   <= gnt ? 2'b10 : 2'b01;
                    state <= ACK;
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    uart_rx_tmo u_tmo (
        .clk         (clk),
        .rst         (rst),
        .push        (fifo_push),
        .pop         (fifo_pop),
        .count_nz    (count_nz),
        .cfg_timeout (cfg_timeout),
        .tmo_flag    (tmo_flag)
    );

`ifdef UART_RX_ARB_DUAL_IRQ_EN
    // Interrupt routed to the owning core only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq0 <= 1'b0;
            irq1 <= 1'b0;
        end else begin
            irq0 <= irq_cond & ~cfg_owner;
            irq1 <= irq_cond & cfg_owner;
        end
    end
`else
    // Registered receive interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_cond;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_arb.sv
// Self-checking bench for uart_rx_arb with a behavioural 16-entry FIFO.
// Table-driven single-core reads plus hand-written multi-cycle sequences.
module tb_uart_rx_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  fifo_count;
    logic [10:0] fifo_data;
    logic        fifo_push = 1'b0;
    logic        fifo_pop;
    logic [1:0]  req = 2'b00;
    logic [1:0]  ack;
    logic [10:0] rd_data;
    logic        rd_empty;
    logic [1:0]  cfg_trig = 2'b11;
    logic [15:0] cfg_timeout = 16'd0;
    logic        irq;
    logic        tmo_flag;

    int tests = 0;
    int fails = 0;

    uart_rx_arb dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_count  (fifo_count),
        .fifo_data   (fifo_data),
        .fifo_push   (fifo_push),
        .fifo_pop    (fifo_pop),
        .req         (req),
        .ack         (ack),
        .rd_data     (rd_data),
        .rd_empty    (rd_empty),
        .cfg_trig    (cfg_trig),
        .cfg_timeout (cfg_timeout),
        .irq         (irq),
        .tmo_flag    (tmo_flag)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO plus protocol monitors
    logic [10:0] mem [16];
    logic [3:0]  rp = 4'd0;
    logic [3:0]  wp = 4'd0;
    logic [4:0]  cnt = 5'd0;
    logic [10:0] push_data = 11'd0;
    logic        pop_q = 1'b0;
    logic        underflow = 1'b0;
    logic        double_pop = 1'b0;
    int          pop_total = 0;

    assign fifo_count = cnt;
    assign fifo_data  = mem[rp];

    initial for (int i = 0; i < 16; i++) mem[i] = 11'd0;

    always @(posedge clk) begin
        if (fifo_pop) rp <= rp + 4'd1;
        if (fifo_push) begin
            mem[wp] <= push_data;
            wp <= wp + 4'd1;
        end
        cnt <= cnt + {4'd0, fifo_push} - {4'd0, fifo_pop};
        if (fifo_pop && cnt == 5'd0) underflow <= 1'b1;
        if (fifo_pop && pop_q) double_pop <= 1'b1;
        if (fifo_pop) pop_total <= pop_total + 1;
        pop_q <= fifo_pop;
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push_word(input logic [10:0] w);
        push_data = w;
        fifo_push = 1'b1;
        @(negedge clk);
        fifo_push = 1'b0;
    endtask

    // Raise req, wait (bounded) for any ack, then drop req
    task automatic do_txn(input logic [1:0] r, output logic [1:0] got);
        bit seen = 0;
        got = 2'b00;
        req = r;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                got = ack;
                seen = 1;
            end
        end
        req = 2'b00;
        if (!seen) check("ack_timeout", 0, 1);
    endtask

    typedef struct {
        bit          do_push;
        logic [10:0] word;
        logic [1:0]  r;
        logic [1:0]  exp_ack;
        logic        exp_empty;
        logic [10:0] exp_data;
        int          exp_pops;
    } vec_t;

    vec_t vt [5];

    initial begin
        logic [1:0]  g;
        logic [1:0]  rr_ack [4];
        logic [10:0] rr_dat [4];
        logic [1:0]  exp_rr [4];
        logic [10:0] words [4];
        int          n;
        int          p0;
        bit          seen;

        vt[0] = '{1'b1, 11'h208, 2'b01, 2'b01, 1'b0, 11'h208, 1};
        vt[1] = '{1'b0, 11'h000, 2'b10, 2'b10, 1'b1, 11'h208, 0};
        vt[2] = '{1'b1, 11'h7FF, 2'b10, 2'b10, 1'b0, 11'h7FF, 1};
        vt[3] = '{1'b1, 11'h005, 2'b01, 2'b01, 1'b0, 11'h005, 1};
        vt[4] = '{1'b0, 11'h000, 2'b01, 2'b01, 1'b1, 11'h005, 0};

        exp_rr[0] = 2'b01; exp_rr[1] = 2'b10;
        exp_rr[2] = 2'b01; exp_rr[3] = 2'b10;
        words[0] = 11'h111; words[1] = 11'h222;
        words[2] = 11'h333; words[3] = 11'h444;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pop", fifo_pop, 0);
        check("rst_ack", ack, 0);
        check("rst_data", rd_data, 0);
        check("rst_empty", rd_empty, 0);
        check("rst_irq", irq, 0);
        check("rst_tmo", tmo_flag, 0);
        rst = 1'b0;
        @(negedge clk);

        // Round robin with both cores requesting
        for (int i = 0; i < 4; i++) push_word(words[i]);
        p0 = pop_total;
        n = 0;
        req = 2'b11;
        for (int c = 0; c < 30 && n < 4; c++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                rr_ack[n] = ack;
                rr_dat[n] = rd_data;
                n++;
                if (n == 4) req = 2'b00;
            end
        end
        req = 2'b00;
        check("rr_count", n, 4);
        for (int i = 0; i < n; i++) begin
            check("rr_ack", rr_ack[i], exp_rr[i]);
            check("rr_data", rr_dat[i], words[i]);
        end
        @(negedge clk);
        check("rr_pops", pop_total - p0, 4);
        check("rr_cnt", cnt, 0);

        // Table of single-core reads
        for (int i = 0; i < 5; i++) begin
            if (vt[i].do_push) push_word(vt[i].word);
            p0 = pop_total;
            do_txn(vt[i].r, g);
            check("vec_ack", g, vt[i].exp_ack);
            check("vec_empty", rd_empty, vt[i].exp_empty);
            check("vec_data", rd_data, vt[i].exp_data);
            check("vec_pops", pop_total - p0, vt[i].exp_pops);
            @(negedge clk);
        end

        // Trigger level 4
        cfg_trig = 2'b01;
        @(negedge clk);
        for (int i = 0; i < 3; i++) push_word(words[i]);
        @(negedge clk);
        check("trig_below", irq, 0);
        push_word(words[3]);
        check("trig_lag", irq, 0);
        @(negedge clk);
        check("trig_hit", irq, 1);
        do_txn(2'b01, g);
        check("trig_data", rd_data, words[0]);
        @(negedge clk);
        check("trig_fall", irq, 0);
        for (int i = 1; i < 4; i++) begin
            do_txn(2'b10, g);
            check("trig_drain", rd_data, words[i]);
            @(negedge clk);
        end
        cfg_trig = 2'b11;

        // Timeout of 10 idle cycles
        cfg_timeout = 16'd10;
        @(negedge clk);
        push_word(11'h155);
        repeat (9) @(negedge clk);
        check("tmo_early", tmo_flag, 0);
        check("tmo_irq_early", irq, 0);
        seen = 0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            if (tmo_flag) seen = 1;
        end
        check("tmo_set", seen, 1);
        @(negedge clk);
        check("tmo_irq", irq, 1);
        do_txn(2'b10, g);
        check("tmo_data", rd_data, 11'h155);
        check("tmo_clr", tmo_flag, 0);
        @(negedge clk);
        check("tmo_irq_clr", irq, 0);

        // Timeout disabled
        cfg_timeout = 16'd0;
        push_word(11'h0F0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tmo_flag) seen = 1;
        end
        check("tmo_off", seen, 0);
        do_txn(2'b01, g);
        check("tmo_off_data", rd_data, 11'h0F0);
        @(negedge clk);

        // Reset while in POP
        push_word(11'h0AA);
        req = 2'b01;
        @(posedge clk);
        #1;
        check("pre_rst_pop", fifo_pop, 1);
        rst = 1'b1;
        #1;
        check("arst_pop", fifo_pop, 0);
        check("arst_ack", ack, 0);
        check("arst_data", rd_data, 0);
        check("arst_empty", rd_empty, 0);
        check("arst_irq", irq, 0);
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_cnt", cnt, 1);
        p0 = pop_total;
        do_txn(2'b01, g);
        check("post_rst_ack", g, 2'b01);
        check("post_rst_data", rd_data, 11'h0AA);
        check("post_rst_empty", rd_empty, 0);
        @(negedge clk);
        check("post_rst_pops", pop_total - p0, 1);

        // Protocol monitors
        check("no_underflow", underflow, 0);
        check("single_pop", double_pop, 0);
        check("final_cnt", cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_arb.md
Name: uart_rx_arb

Overview:
- Read-side controller for the UART receive FIFO in the dual-core system.
- Shares the single FIFO pop port between two CPU cores using round-robin arbitration.
- Sequences each pop, captures the head word (8-bit data plus 3 status bits), and returns it to the winning core.
- Generates the receive interrupt from the trigger level and a character-timeout timer, so the FIFO's read_empty flag is never set by a core.

Parameters:
- FIFO_DEPTH, 16, FIFO entries; count range 0..FIFO_DEPTH.
- CNT_W, 5, width of the FIFO count input.
- DATA_W, 11, FIFO word width; [10:3] = data byte, [2:0] = break/framing/parity flags.
- TMO_W, 16, width of the timeout counter and of cfg_timeout.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- fifo_count  in  CNT_W  FIFO occupancy.
- fifo_data  in  DATA_W  FIFO head word, combinational from FIFO.
- fifo_push  in  1  FIFO push strobe from the receiver; used for timeout.
- fifo_pop  out  1  pop strobe to FIFO, single-cycle.
- req  in  2  per-core read request, level, held until ack.
- ack  out  2  per-core one-cycle acknowledge.
- rd_data  out  DATA_W  captured word, valid with ack, held until the next capture.
- rd_empty  out  1  qualifies ack: FIFO was empty, no pop issued.
- cfg_trig  in  2  trigger level: 00=1, 01=4, 10=8, 11=14.
- cfg_timeout  in  TMO_W  idle cycles before timeout; 0 disables timeout.
- irq  out  1  receive interrupt, level.
- tmo_flag  out  1  timeout pending, readable status.

Behaviour:
- Reset values: fifo_pop=0, ack=00, rd_data=0, rd_empty=0, irq=0, tmo_flag=0, FSM=IDLE, rr_last=1 (core 0 wins first), timer=0.
- FSM states are IDLE, POP, ACK.
- IDLE:
  - If any req bit is set, pick a winner. If only one bit is set, that core wins. If both are set, the core other than rr_last wins.
  - Register the winner in gnt and update rr_last to the winner.
  - Go to POP.
- POP (one cycle):
  - If fifo_count!=0: fifo_pop=1, rd_data<=fifo_data (the head is sampled in the pop cycle), rd_empty<=0.
  - If fifo_count==0: fifo_pop=0, rd_empty<=1, rd_data unchanged.
  - Go to ACK.
- ACK (one cycle): ack[gnt]=1, then go to IDLE.
- Latency is 3 cycles from a req rise in IDLE to ack. Core throughput is one word per 3 cycles.
- A core must drop req in the cycle after ack. A req still high in IDLE is a new request.
- If req drops while in POP or ACK, the transaction completes anyway; the ack is ignored and the word is consumed.
- A push in the same cycle as a pop is legal and the FIFO handles it. If count was 0 at POP sampling, the transaction is treated as empty even if a push lands that cycle.
- fifo_pop is never asserted when fifo_count==0 and is never asserted for more than one cycle.
- Trigger: trig_hit = fifo_count >= level(cfg_trig), with count compared at CNT_W width.
- Timeout timer:
  - Clears on fifo_push, on fifo_pop, or when fifo_count==0.
  - Otherwise increments, saturating at cfg_timeout.
  - tmo_flag is set when timer==cfg_timeout, cfg_timeout!=0 and fifo_count!=0.
  - tmo_flag clears on the next fifo_pop or fifo_push, or when count reaches 0.
- irq is registered: irq <= trig_hit | tmo_flag. It therefore lags its causes by one cycle.
- Changing cfg_timeout mid-count takes effect immediately; if timer>cfg_timeout, the timer saturates to the new value next cycle.
- rst asserted mid-transaction aborts to IDLE; any pop already issued is not undone.

Optional Feature:
- Macro: UART_RX_ARB_DUAL_IRQ_EN.
- Enabled:
  - irq is replaced by irq0 and irq1, and an input cfg_owner (1 bit) is added.
  - The interrupt condition drives only irq[cfg_owner]; the other output is 0.
  - Arbitration is unchanged.
- Disabled: single irq output, no cfg_owner port.

Decomposition:
- Shared package uart_rx_pkg holds:
  - FSM state encoding: IDLE=2'd0, POP=2'd1, ACK=2'd2.
  - Trigger-level constants 1/4/8/14 and the cfg_trig decode function.
  - DATA_W and the bit-field indices of the FIFO word.
- One sub-module, uart_rx_tmo: the timeout counter and flag, with inputs push, pop, count_nz, cfg_timeout and output tmo_flag.

Test Plan:
- FIFO holding 0x41 (flags 0), core 0 req → one fifo_pop in cycle 2, ack[0] in cycle 3, rd_data=11'h208, rd_empty=0, fifo_count 1→0.
- Both req high with 4 words queued → acks alternate 0,1,0,1; exactly 4 pops; rd_data returned in FIFO order.
- Empty FIFO, core 1 req → ack[1] with rd_empty=1, fifo_pop never asserted, FIFO read_empty stays 0.
- cfg_trig=01, push 3 words → irq=0; on the 4th push, irq=1 one cycle after count reaches 4; one pop → irq falls.
- cfg_timeout=10, 1 word, no activity → tmo_flag=1 after 10 idle cycles and irq follows; a pop clears both; with cfg_timeout=0, tmo_flag is never set.
- rst pulsed while in POP → all outputs return to reset values asynchronously; the next req is served normally.
